pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 tb/tb_pc_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer with a circular return-address stack.
//
// Computes the next program counter each enabled cycle from the mode input
// (sequential, branch, jump, call, return, hold). Calls push the wrapped
// return address (pc+1) onto a RAS_DEPTH-entry circular stack; returns pop it.
// Overflow (call while full) overwrites the oldest entry; underflow (return
// while empty) falls through to pc+1. Both raise sticky flags.
//
// Parameters
//   PC_W      program-counter width in bits (4..16)
//   RAS_DEPTH return-address-stack entries (2..16)
//   RESET_PC  pc value loaded on reset
//
// Ports
//   CLOCK_50   in   1     single clock, rising edge
//   reset      in   1     asynchronous, active-low reset
//   enable     in   1     1 = advance, 0 = stall (flush/err_clr still act)
//   mode       in   3     000 seq, 001 branch, 010 jump, 011 call, 100 return,
//                         101..111 hold
//   br_taken   in   1     branch condition (mode 001 only)
//   br_target  in   PC_W  branch target
//   j_imm      in   PC_W  jump/call target
//   flush      in   1     clear the return stack, suppress this cycle's push/pop
//   err_clr    in   1     clear sticky ovf/unf (a same-cycle new error wins)
//   pc         out  PC_W  registered program counter
//   ras_count  out  5     valid stack entries, 0..RAS_DEPTH
//   ras_full   out  1     ras_count == RAS_DEPTH
//   ras_empty  out  1     ras_count == 0
//   ovf        out  1     sticky stack overflow
//   unf        out  1     sticky stack underflow

module pc_sequencer #(
  parameter int unsigned PC_W      = 12,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            enable,
  input  logic [2:0]      mode,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] j_imm,
  input  logic            flush,
  input  logic            err_clr,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      ras_count,
  output logic            ras_full,
  output logic            ras_empty,
  output logic            ovf,
  output logic            unf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [4:0]       FULL_CNT = 5'(RAS_DEPTH);

  typedef enum logic [2:0] {
    MODE_SEQ  = 3'b000,
    MODE_BR   = 3'b001,
    MODE_JMP  = 3'b010,
    MODE_CALL = 3'b011,
    MODE_RET  = 3'b100
  } mode_e;

  logic [PC_W-1:0]  stack [RAS_DEPTH];
  // wr_ptr is the slot the next push writes; when full it is also the oldest
  // entry, so an overflowing push naturally overwrites it.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_ptr_inc;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_nxt;
  logic            do_push;
  logic            do_pop;
  logic            ovf_set;
  logic            unf_set;

  assign pc_inc     = pc + PC_W'(1);
  assign top_idx    = (wr_ptr == '0) ? LAST_IDX : wr_ptr - PTR_W'(1);
  assign wr_ptr_inc = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);

  assign ras_full  = (ras_count == FULL_CNT);
  assign ras_empty = (ras_count == '0);

  always_comb begin
    pc_nxt  = pc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (mode_e'(mode))
      MODE_SEQ: pc_nxt = pc_inc;
      MODE_BR:  pc_nxt = br_taken ? br_target : pc_inc;
      MODE_JMP: pc_nxt = j_imm;
      MODE_CALL: begin
        pc_nxt  = j_imm;
        do_push = !flush;
        ovf_set = !flush && ras_full;
      end
      MODE_RET: begin
        // Flush and underflow both fall through to pc+1; only a genuine
        // empty-stack return (without flush) counts as an underflow.
        if (flush || ras_empty) begin
          pc_nxt  = pc_inc;
          unf_set = !flush;
        end else begin
          pc_nxt = stack[top_idx];
          do_pop = 1'b1;
        end
      end
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pc        <= PC_W'(RESET_PC);
      ras_count <= '0;
      wr_ptr    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      if (enable) begin
        pc <= pc_nxt;
      end

      if (flush) begin
        ras_count <= '0;
        wr_ptr    <= '0;
      end else if (enable && do_push) begin
        wr_ptr <= wr_ptr_inc;
        if (!ras_full) begin
          ras_count <= ras_count + 5'd1;
        end
      end else if (enable && do_pop) begin
        wr_ptr    <= top_idx;
        ras_count <= ras_count - 5'd1;
      end

      ovf <= (enable && ovf_set) || (ovf && !err_clr);
      unf <= (enable && unf_set) || (unf && !err_clr);
    end
  end

  // Stack storage carries no reset; its contents are meaningless while
  // ras_count says they are invalid.
  always_ff @(posedge CLOCK_50) begin
    if (reset && enable && do_push) begin
      stack[wr_ptr] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        CLOCK_50;
  logic        reset;
  logic        enable;
  logic [2:0]  mode;
  logic        br_taken;
  logic [11:0] br_target;
  logic [11:0] j_imm;
  logic        flush;
  logic        err_clr;
  logic [11:0] pc;
  logic [4:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic        ovf;
  logic        unf;

  int n_pass  = 0;
  int n_total = 0;

  pc_sequencer #(
    .PC_W      (12),
    .RAS_DEPTH (4),
    .RESET_PC  (0)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .br_taken  (br_taken),
    .br_target (br_target),
    .j_imm     (j_imm),
    .flush     (flush),
    .err_clr   (err_clr),
    .pc        (pc),
    .ras_count (ras_count),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive inputs, let one rising edge pass, return 1 time unit after it.
  task automatic step(input logic e, input logic [2:0] m, input logic [11:0] imm);
    enable    = e;
    mode      = m;
    j_imm     = imm;
    br_target = imm;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk_stack(input string tag, input logic [11:0] epc, input logic [4:0] ecnt);
    chk({tag, ".pc"}, 16'(pc), 16'(epc));
    chk({tag, ".cnt"}, 16'(ras_count), 16'(ecnt));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; mode = 3'b101; br_taken = 1'b0;
    br_target = '0; j_imm = '0; flush = 1'b0; err_clr = 1'b0;

    // Reset state
    #1;
    chk("rst.pc", 16'(pc), 16'h000);
    chk("rst.cnt", 16'(ras_count), 16'd0);
    chk("rst.empty", 16'(ras_empty), 16'd1);
    chk("rst.full", 16'(ras_full), 16'd0);
    chk("rst.ovf", 16'(ovf), 16'd0);
    chk("rst.unf", 16'(unf), 16'd0);
    #6 reset = 1'b1;

    // Sequential wrap
    step(1, 3'b010, 12'hFFE); chk("jmp.ffe", 16'(pc), 16'hFFE);
    step(1, 3'b000, 12'h000); chk("seq.fff", 16'(pc), 16'hFFF);
    step(1, 3'b000, 12'h000); chk("seq.wrap", 16'(pc), 16'h000);
    step(1, 3'b000, 12'h000); chk("seq.001", 16'(pc), 16'h001);

    // Branch and stall
    step(1, 3'b010, 12'h010); chk("jmp.010", 16'(pc), 16'h010);
    br_taken = 1'b0;
    step(1, 3'b001, 12'h200); chk("br.nt", 16'(pc), 16'h011);
    br_taken = 1'b1;
    step(1, 3'b001, 12'h200); chk("br.t", 16'(pc), 16'h200);
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 3'b000, 12'h000); chk("stall", 16'(pc), 16'h200);
    end
    step(1, 3'b111, 12'h000); chk("hold", 16'(pc), 16'h200);

    // Nested calls: from 0x005, 0x200, 0x300 push 0x006, 0x201, 0x301
    step(1, 3'b010, 12'h005); chk("jmp.005", 16'(pc), 16'h005);
    step(1, 3'b011, 12'h200); chk_stack("call1", 12'h200, 5'd1);
    chk("call1.empty", 16'(ras_empty), 16'd0);
    step(1, 3'b011, 12'h300); chk_stack("call2", 12'h300, 5'd2);
    step(1, 3'b011, 12'h100); chk_stack("call3", 12'h100, 5'd3);
    step(1, 3'b100, 12'h000); chk_stack("ret1", 12'h301, 5'd2);
    step(1, 3'b100, 12'h000); chk_stack("ret2", 12'h201, 5'd1);
    step(1, 3'b100, 12'h000); chk_stack("ret3", 12'h006, 5'd0);
    chk("ret3.empty", 16'(ras_empty), 16'd1);

    // Overflow: calls from 0x006, 0x010, 0x020, 0x030, 0x040
    step(1, 3'b011, 12'h010); chk_stack("oc1", 12'h010, 5'd1);
    step(1, 3'b011, 12'h020); chk_stack("oc2", 12'h020, 5'd2);
    step(1, 3'b011, 12'h030); chk_stack("oc3", 12'h030, 5'd3);
    step(1, 3'b011, 12'h040); chk_stack("oc4", 12'h040, 5'd4);
    chk("oc4.full", 16'(ras_full), 16'd1);
    chk("oc4.ovf", 16'(ovf), 16'd0);
    step(1, 3'b011, 12'h050); chk_stack("oc5", 12'h050, 5'd4);
    chk("oc5.ovf", 16'(ovf), 16'd1);
    chk("oc5.full", 16'(ras_full), 16'd1);
    step(1, 3'b100, 12'h000); chk_stack("or1", 12'h041, 5'd3);
    step(1, 3'b100, 12'h000); chk_stack("or2", 12'h031, 5'd2);
    step(1, 3'b100, 12'h000); chk_stack("or3", 12'h021, 5'd1);
    step(1, 3'b100, 12'h000); chk_stack("or4", 12'h011, 5'd0);
    chk("or4.unf", 16'(unf), 16'd0);
    step(1, 3'b100, 12'h000); chk_stack("or5", 12'h012, 5'd0);
    chk("or5.unf", 16'(unf), 16'd1);
    chk("or5.ovf", 16'(ovf), 16'd1);
    err_clr = 1'b1;
    step(1, 3'b101, 12'h000);
    err_clr = 1'b0;
    chk("clr.ovf", 16'(ovf), 16'd0);
    chk("clr.unf", 16'(unf), 16'd0);
    chk("clr.pc", 16'(pc), 16'h012);

    // Set wins over err_clr: empty-stack return with err_clr
    err_clr = 1'b1;
    step(1, 3'b100, 12'h000);
    err_clr = 1'b0;
    chk("setwin.unf", 16'(unf), 16'd1);
    chk("setwin.pc", 16'(pc), 16'h013);
    err_clr = 1'b1;
    step(0, 3'b000, 12'h000);
    err_clr = 1'b0;
    chk("stallclr.unf", 16'(unf), 16'd0);
    chk("stallclr.pc", 16'(pc), 16'h013);

    // Flush plus call
    step(1, 3'b011, 12'h100); chk_stack("fc1", 12'h100, 5'd1);
    step(1, 3'b011, 12'h200); chk_stack("fc2", 12'h200, 5'd2);
    flush = 1'b1;
    step(1, 3'b011, 12'h040);
    flush = 1'b0;
    chk_stack("flush", 12'h040, 5'd0);
    chk("flush.ovf", 16'(ovf), 16'd0);
    chk("flush.empty", 16'(ras_empty), 16'd1);

    // Asynchronous reset mid-sequence
    step(1, 3'b011, 12'h300);
    step(1, 3'b011, 12'h310);
    step(1, 3'b011, 12'h123); chk_stack("pre.rst", 12'h123, 5'd3);
    #2 reset = 1'b0;
    #1;
    chk_stack("arst", 12'h000, 5'd0);
    chk("arst.empty", 16'(ras_empty), 16'd1);
    #2 reset = 1'b1;
    step(1, 3'b000, 12'h000); chk_stack("post.rst", 12'h001, 5'd0);
    step(1, 3'b100, 12'h000); chk_stack("post.ret", 12'h002, 5'd0);
    chk("post.unf", 16'(unf), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
